cdb_arbiter: RTL

- Arbitrates the single common data bus (CDB) between NUM_REQ functional-unit result requesters, granting at most one result per cycle.
- Broadcasts the winning result in one registered cycle to the reservation-station retire port, the physical register file write port and the busy-table clear port.
- Sits between the execution units and the res_st / phy_rf / busy_table write interfaces inside back_end.

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 40 ++++
 rtl/cdb_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: result-bus types shared by the CDB arbiter and its clients
package cdb_arbiter_pkg;
    localparam int ROB_ADDR_W    = 5;
    localparam int PHY_RF_ADDR_W = 6;
    localparam int PHY_RF_DATA_W = 32;

    typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
    typedef logic [PHY_RF_ADDR_W-1:0] phy_rf_addr_t;
    typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;

    typedef struct packed {
        rob_addr_t    rob_addr;
        phy_rf_addr_t dest;
        phy_rf_data_t value;
    } cdb_pkt_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with a pointer that advances past each winner
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_any
);
    logic [PTR_W-1:0] r_ptr;

    always_comb begin
        int j;
        j = 0;
        o_grant = '0;
        o_grant_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(r_ptr) + k) % NUM_REQ;
            if (i_en && !o_any && i_req[j]) begin
                o_grant[j] = 1'b1;
                o_grant_idx = PTR_W'(j);
                o_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_ptr <= '0;
        else if (i_clr)
            r_ptr <= '0;
        else if (o_any)
            r_ptr <= (o_grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one result per cycle onto the CDB and broadcasts it a cycle later.
// Define QU_CDB_PERF_EN to add saturating per-requester grant and conflict counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cdb_en,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  rob_addr_t          req_rob_addr [NUM_REQ],
    input  phy_rf_addr_t       req_dest     [NUM_REQ],
    input  phy_rf_data_t       req_value    [NUM_REQ],
    output logic               res_st_retire_en,
    output rob_addr_t          res_st_retire_rob_addr,
    output phy_rf_data_t       res_st_retire_value,
    output logic               phy_rf_wr_en,
    output phy_rf_addr_t       phy_rf_wr_addr,
    output phy_rf_data_t       phy_rf_wr_data,
    output logic               busy_table_wr_en,
    output phy_rf_addr_t       busy_table_wr_addr,
`ifdef QU_CDB_PERF_EN
    output logic [31:0]        perf_grant_cnt [NUM_REQ],
    output logic [31:0]        perf_conflict_cnt,
`endif
    output logic               busy_table_wr_data
);
    cdb_pkt_t         w_pkt [NUM_REQ];
    logic             w_any;
    logic             w_bcast;
    logic [PTR_W-1:0] w_idx;
    logic             r_valid;
    cdb_pkt_t         r_pkt;

    always_comb
        for (int i = 0; i < NUM_REQ; i++)
            w_pkt[i] = '{rob_addr: req_rob_addr[i], dest: req_dest[i], value: req_value[i]};

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (cdb_en && !flush && !rst),
        .i_clr      (flush),
        .i_req      (req_valid),
        .o_grant    (req_ready),
        .o_grant_idx(w_idx),
        .o_any      (w_any)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_valid <= 1'b0;
            r_pkt <= '0;
        end else begin
            r_valid <= w_any;
            if (w_any)
                r_pkt <= w_pkt[w_idx];
        end

    // flush squashes a broadcast already latched for the current cycle
    assign w_bcast                = r_valid && !flush;
    assign res_st_retire_en       = w_bcast;
    assign res_st_retire_rob_addr = r_pkt.rob_addr;
    assign res_st_retire_value    = r_pkt.value;
    assign phy_rf_wr_en           = w_bcast && (r_pkt.dest != '0);
    assign phy_rf_wr_addr         = r_pkt.dest;
    assign phy_rf_wr_data         = r_pkt.value;
    assign busy_table_wr_en       = phy_rf_wr_en;
    assign busy_table_wr_addr     = r_pkt.dest;
    assign busy_table_wr_data     = 1'b0;

`ifdef QU_CDB_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst || flush) begin
            for (int i = 0; i < NUM_REQ; i++)
                perf_grant_cnt[i] <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i])
                    perf_grant_cnt[i] <= sat_inc(perf_grant_cnt[i]);
            if (w_any && $countones(req_valid) >= 2)
                perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
        end
`endif
endmodule
